// File: rtl/tl_pkg.sv
// Shared light encoding and gap-timer constants for the traffic-light controller and its environment model.
package tl_pkg;

    typedef logic [1:0] light_t;

    localparam light_t GREEN   = 2'b00;
    localparam light_t YELLOW  = 2'b01;
    localparam light_t RED     = 2'b10;
    localparam light_t ILLEGAL = 2'b11;

    localparam int GAP_W          = 4;
    localparam int DEPART_GAP_MIN = 1;
    localparam int DEPART_GAP_MAX = 15;

endpackage

// File: rtl/tl_street_queue.sv
// One street's car queue: saturating counter, departure gap timer, departure pulse and presence flag.
module tl_street_queue
    import tl_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int DEPART_GAP = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arr,
    input  light_t           light,
    output logic [CNT_W-1:0] cnt,
    output logic             dep,
    output logic             present,
    output logic             drop
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DEPART_GAP - 1);

    logic [GAP_W-1:0] gap;
    logic             depart;
    logic             arrive;
    logic             full;

    always_comb begin
        full   = (cnt == CNT_MAX);
        depart = (light == GREEN) && (cnt != '0) && (gap == '0);
        // A departing car frees a slot, so an arrival at saturation still fits.
        arrive = arr && !(full && !depart);
        drop   = arr && full && !depart;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            gap <= '0;
            dep <= 1'b0;
        end else begin
            if (arrive && !depart) begin
                cnt <= cnt + CNT_W'(1);
            end else if (depart && !arrive) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (depart) begin
                gap <= GAP_LOAD;
            end else if (gap != '0) begin
                gap <= gap - GAP_W'(1);
            end
            dep <= depart;
        end
    end

    assign present = (cnt != '0);

endmodule

// File: rtl/tl_traffic_model.sv
// Intersection environment model: two street queues driving Ta/Tb from the controller's La/Lb.
// Optional light-protocol checker enabled by defining TL_SAFETY_CHECK_EN; otherwise err is tied 0.
module tl_traffic_model
    import tl_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int DEPART_GAP = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_a_arr,
    input  logic             car_b_arr,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    output logic             Ta,
    output logic             Tb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             dep_a,
    output logic             dep_b,
    output logic             ovf,
    output logic             err
);

    logic drop_a;
    logic drop_b;

    tl_street_queue #(
        .CNT_W      (CNT_W),
        .DEPART_GAP (DEPART_GAP)
    ) u_queue_a (
        .clk     (clk),
        .reset   (reset),
        .arr     (car_a_arr),
        .light   (La),
        .cnt     (cnt_a),
        .dep     (dep_a),
        .present (Ta),
        .drop    (drop_a)
    );

    tl_street_queue #(
        .CNT_W      (CNT_W),
        .DEPART_GAP (DEPART_GAP)
    ) u_queue_b (
        .clk     (clk),
        .reset   (reset),
        .arr     (car_b_arr),
        .light   (Lb),
        .cnt     (cnt_b),
        .dep     (dep_b),
        .present (Tb),
        .drop    (drop_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf | drop_a | drop_b;
        end
    end

`ifdef TL_SAFETY_CHECK_EN
    light_t prev_a;
    light_t prev_b;
    logic   viol;

    // Skipping yellow (G->R) and R->Y are both illegal sequencing.
    always_comb begin
        viol = (La == ILLEGAL) || (Lb == ILLEGAL)
            || ((La != RED) && (Lb != RED))
            || ((prev_a == GREEN) && (La == RED))
            || ((prev_a == RED) && (La == YELLOW))
            || ((prev_b == GREEN) && (Lb == RED))
            || ((prev_b == RED) && (Lb == YELLOW));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_a <= RED;
            prev_b <= RED;
            err    <= 1'b0;
        end else begin
            prev_a <= La;
            prev_b <= Lb;
            err    <= err | viol;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_traffic_model.sv
// Bench for tl_traffic_model: scripted scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-level model. Define TL_SAFETY_CHECK_EN to also model err.
module tb_tl_traffic_model;
    import tl_pkg::*;

    localparam int CNT_W = 4;
    localparam int GAP   = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             car_a_arr;
    logic             car_b_arr;
    logic [1:0]       La;
    logic [1:0]       Lb;
    logic             Ta;
    logic             Tb;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             dep_a;
    logic             dep_b;
    logic             ovf;
    logic             err;

    always #5 clk = ~clk;

    tl_traffic_model #(
        .CNT_W      (CNT_W),
        .DEPART_GAP (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .car_a_arr (car_a_arr),
        .car_b_arr (car_b_arr),
        .La        (La),
        .Lb        (Lb),
        .Ta        (Ta),
        .Tb        (Tb),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .dep_a     (dep_a),
        .dep_b     (dep_b),
        .ovf       (ovf),
        .err       (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: queue lengths, edge index of each street's last departure.
    int         m_cnt  [2];
    int         m_last [2];
    bit         m_dep  [2];
    bit         m_ovf;
    bit         m_err;
    logic [1:0] m_prev [2];
    int         edge_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s]  = 0;
            m_last[s] = -1000;
            m_dep[s]  = 1'b0;
            m_prev[s] = RED;
        end
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0] lt [2];
        bit         ar [2];
        bit         dok, aok, viol;
        lt[0] = La;        lt[1] = Lb;
        ar[0] = car_a_arr; ar[1] = car_b_arr;
        if (reset) begin
            model_reset();
        end else begin
            viol = (lt[0] == 2'b11) || (lt[1] == 2'b11) || (lt[0] != RED && lt[1] != RED);
            for (int s = 0; s < 2; s++) begin
                if (m_prev[s] == GREEN && lt[s] == RED)  viol = 1'b1;
                if (m_prev[s] == RED && lt[s] == YELLOW) viol = 1'b1;
                dok = (lt[s] == GREEN) && (m_cnt[s] > 0) && (edge_n - m_last[s] >= GAP);
                aok = ar[s] && !(m_cnt[s] == CMAX && !dok);
                if (ar[s] && !aok) m_ovf = 1'b1;
                m_cnt[s] = m_cnt[s] + int'(aok) - int'(dok);
                if (dok) m_last[s] = edge_n;
                m_dep[s]  = dok;
                m_prev[s] = lt[s];
            end
`ifdef TL_SAFETY_CHECK_EN
            if (viol) m_err = 1'b1;
`endif
        end
        edge_n++;
    endtask

    task automatic compare();
        check("cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
        check("cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
        check("Ta",    32'(Ta),    32'(m_cnt[0] != 0));
        check("Tb",    32'(Tb),    32'(m_cnt[1] != 0));
        check("dep_a", 32'(dep_a), 32'(m_dep[0]));
        check("dep_b", 32'(dep_b), 32'(m_dep[1]));
        check("ovf",   32'(ovf),   32'(m_ovf));
        check("err",   32'(err),   32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    bit exp_err_on;

    initial begin
`ifdef TL_SAFETY_CHECK_EN
        exp_err_on = 1'b1;
`else
        exp_err_on = 1'b0;
`endif
        model_reset();
        reset = 1'b1; car_a_arr = 1'b0; car_b_arr = 1'b0; La = RED; Lb = RED;
        step(); step();
        check("lit_reset_cnt_a", 32'(cnt_a), 0);
        check("lit_reset_Ta",    32'(Ta),    0);
        check("lit_reset_ovf",   32'(ovf),   0);
        check("lit_reset_err",   32'(err),   0);
        reset = 1'b0;
        step();

        // Three arrivals on red.
        car_a_arr = 1'b1;
        step();
        check("lit_Ta_first_arrival", 32'(Ta), 1);
        step(); step();
        car_a_arr = 1'b0;
        check("lit_cnt_a_3", 32'(cnt_a), 3);
        check("lit_no_dep_on_red", 32'(dep_a), 0);

        // Green drains one car every GAP cycles: dep_a at 1,4,7.
        La = GREEN;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("lit_dep_a_pace", 32'(dep_a), 32'(i == 1 || i == 4 || i == 7));
            if (i == 1) check("lit_cnt_a_2", 32'(cnt_a), 2);
            if (i == 4) check("lit_cnt_a_1", 32'(cnt_a), 1);
            if (i == 7) begin
                check("lit_cnt_a_0", 32'(cnt_a), 0);
                check("lit_Ta_falls", 32'(Ta), 0);
            end
        end
        La = YELLOW; step();
        La = RED;    step();

        // Arrival coincident with departure.
        car_a_arr = 1'b1; step(); step();
        La = GREEN; step();
        check("lit_coincident_cnt", 32'(cnt_a), 2);
        check("lit_coincident_dep", 32'(dep_a), 1);
        car_a_arr = 1'b0;
        La = YELLOW; step();
        La = RED;    step();

        // Saturation on street B.
        car_b_arr = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) check("lit_ovf_before_16th", 32'(ovf), 0);
        end
        check("lit_cnt_b_sat", 32'(cnt_b), 15);
        check("lit_ovf_set",   32'(ovf),   1);
        Lb = GREEN; step();
        check("lit_sat_accept_cnt", 32'(cnt_b), 15);
        check("lit_sat_accept_dep", 32'(dep_b), 1);
        car_b_arr = 1'b0;
        Lb = YELLOW; step();
        Lb = RED;    step();
        check("lit_legal_seq_err", 32'(err), 0);
        check("lit_ovf_sticky",    32'(ovf), 1);

        // Protocol violations.
        La = GREEN; step();
        La = RED;   step();
        check("lit_g_to_r_err", 32'(err), 32'(exp_err_on));
        step();
        check("lit_err_sticky", 32'(err), 32'(exp_err_on));
        reset = 1'b1; step();
        reset = 1'b0;
        La = GREEN; Lb = GREEN; step();
        check("lit_both_green_err", 32'(err), 32'(exp_err_on));

        // Reset mid-operation with a running gap timer.
        reset = 1'b1; La = RED; Lb = RED; step();
        reset = 1'b0;
        car_a_arr = 1'b1;
        for (int i = 0; i < 6; i++) step();
        car_a_arr = 1'b0;
        La = GREEN; step();
        check("lit_mid_cnt_5", 32'(cnt_a), 5);
        reset = 1'b1; step();
        check("lit_mid_reset_cnt", 32'(cnt_a), 0);
        check("lit_mid_reset_Ta",  32'(Ta),    0);
        reset = 1'b0; car_a_arr = 1'b1; step();
        car_a_arr = 1'b0; step();
        check("lit_post_reset_dep", 32'(dep_a), 1);
        La = YELLOW; step();
        La = RED;    step();

        // Randomized traffic, lights and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            int rate;
            rate = ((i / 400) % 2 == 1) ? 75 : 20;
            reset     = ($urandom_range(0, 299) == 0);
            car_a_arr = ($urandom_range(0, 99) < rate);
            car_b_arr = ($urandom_range(0, 99) < rate);
            if ($urandom_range(0, 9) == 0) La = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) Lb = 2'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
